// File: rtl/vga_char_pkg.sv
// -----------------------------------------------------------------------------
// vga_char_pkg
// Shared constants and types for the 16x16 character text overlay.
//   - glyph and grid geometry (8x16 glyphs, 16x16 cells, 128x256 px box)
//   - bus widths for VGA counters, RGB444 colour, char codes and font address
//   - packed structs for the timing bundle and the per-pixel side pipeline
//   - font_pixel(): picks one pixel out of a font line, MSB = leftmost
// -----------------------------------------------------------------------------
package vga_char_pkg;

    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int GRID_COLS   = 16;
    localparam int GRID_ROWS   = 16;
    localparam int BOX_W       = CHAR_W * GRID_COLS;   // 128
    localparam int BOX_H       = CHAR_H * GRID_ROWS;   // 256

    localparam int COUNT_W     = 11;
    localparam int RGB_W       = 12;
    localparam int CHAR_CODE_W = 7;
    localparam int FONT_ADDR_W = 11;

    // VGA timing bundle carried through the fixed-latency delay line.
    typedef struct packed {
        logic [COUNT_W-1:0] hcount;
        logic               hsync;
        logic               hblnk;
        logic [COUNT_W-1:0] vcount;
        logic               vsync;
        logic               vblnk;
    } timing_t;

    // Per-pixel information needed at the compositing stage.
    typedef struct packed {
        logic [2:0]       bit_idx;
        logic             in_box;
        logic             blank;
        logic [RGB_W-1:0] rgb;
    } side_t;

    // Font lines are stored with the leftmost pixel in the MSB.
    function automatic logic font_pixel(input logic [CHAR_W-1:0] line,
                                        input logic [2:0]        idx);
        return line[3'd7 - idx];
    endfunction

endpackage

// File: rtl/signal_delay.sv
// -----------------------------------------------------------------------------
// signal_delay
// Fixed-latency shift register: dout is din delayed by CLK_DEL clock cycles.
// All stages clear to 0 on the asynchronous active-low reset.
// Parameters: WIDTH   - data width
//             CLK_DEL - number of register stages (>= 1)
// Ports:      clk, rst_n, din[WIDTH], dout[WIDTH]
// -----------------------------------------------------------------------------
module signal_delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [CLK_DEL-1:0][WIDTH-1:0] stage_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CLK_DEL; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= din;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = stage_reg[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char_16x16.sv
// -----------------------------------------------------------------------------
// draw_rect_char_16x16
// Pipelined VGA text overlay: reads a 16x16 character grid from an external
// char ROM (combinational) and the glyph lines from an external font ROM
// (1-cycle synchronous read), then serialises glyph pixels onto the RGB stream.
//
// Pipeline (edge numbers after an input sample):
//   1: char_xy = {row, col}, side info captured
//   2: font_addr = {char_code, glyph line}
//   3: font ROM registers font_addr (external)
//   4: rgb_out composited; timing/counters delayed by the same 4 cycles
//
// Parameters: XPOS, YPOS     - top-left corner of the 128x256 px text box
//             LETTER_COLOR   - colour of set glyph pixels
//             BG_COLOR       - box background (opaque mode only)
// Macro:      CHAR_BG_EN     - when defined, unset glyph pixels inside the box
//                              show BG_COLOR; otherwise the box is transparent
// Ports:  pclk, rst_n (async, active-low)
//         hcount_in/vcount_in, hsync_in/vsync_in, hblnk_in/vblnk_in, rgb_in
//         char_code (from char ROM), char_pixels (from font ROM)
//         char_xy (to char ROM), font_addr (to font ROM)
//         hcount_out/vcount_out, hsync_out/vsync_out, hblnk_out/vblnk_out,
//         rgb_out
// -----------------------------------------------------------------------------
module draw_rect_char_16x16
    import vga_char_pkg::*;
#(
    parameter logic [COUNT_W-1:0] XPOS         = '0,
    parameter logic [COUNT_W-1:0] YPOS         = '0,
    parameter logic [RGB_W-1:0]   LETTER_COLOR = 12'hFFF,
    parameter logic [RGB_W-1:0]   BG_COLOR     = 12'h000
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic [COUNT_W-1:0]     hcount_in,
    input  logic                   hsync_in,
    input  logic                   hblnk_in,
    input  logic [COUNT_W-1:0]     vcount_in,
    input  logic                   vsync_in,
    input  logic                   vblnk_in,
    input  logic [RGB_W-1:0]       rgb_in,
    input  logic [CHAR_CODE_W-1:0] char_code,
    input  logic [CHAR_W-1:0]      char_pixels,
    output logic [7:0]             char_xy,
    output logic [FONT_ADDR_W-1:0] font_addr,
    output logic [COUNT_W-1:0]     hcount_out,
    output logic [COUNT_W-1:0]     vcount_out,
    output logic                   hsync_out,
    output logic                   hblnk_out,
    output logic                   vsync_out,
    output logic                   vblnk_out,
    output logic [RGB_W-1:0]       rgb_out
);

`ifdef CHAR_BG_EN
    localparam bit OPAQUE_BOX = 1'b1;
`else
    localparam bit OPAQUE_BOX = 1'b0;
`endif

    // Box limits widened by one bit so XPOS+128 / YPOS+256 cannot wrap.
    localparam logic [COUNT_W:0] X_LO = {1'b0, XPOS};
    localparam logic [COUNT_W:0] Y_LO = {1'b0, YPOS};
    localparam logic [COUNT_W:0] X_HI = X_LO + (COUNT_W+1)'(BOX_W);
    localparam logic [COUNT_W:0] Y_HI = Y_LO + (COUNT_W+1)'(BOX_H);

    // ------------------------------------------------------------------
    // Stage 0: combinational decode of the incoming pixel position.
    // Only the low bits of rx/ry are ever used, and the low bits of a
    // difference depend only on the low bits of its operands.
    // ------------------------------------------------------------------
    logic [6:0] rx;
    logic [7:0] ry;
    logic       in_box;

    assign rx = hcount_in[6:0] - XPOS[6:0];
    assign ry = vcount_in[7:0] - YPOS[7:0];

    assign in_box = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                    ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);

    side_t   side_s0, side_s3;
    timing_t timing_s0, timing_s4;

    assign side_s0.bit_idx = rx[2:0];
    assign side_s0.in_box  = in_box;
    assign side_s0.blank   = hblnk_in | vblnk_in;
    assign side_s0.rgb     = rgb_in;

    assign timing_s0.hcount = hcount_in;
    assign timing_s0.hsync  = hsync_in;
    assign timing_s0.hblnk  = hblnk_in;
    assign timing_s0.vcount = vcount_in;
    assign timing_s0.vsync  = vsync_in;
    assign timing_s0.vblnk  = vblnk_in;

    // ------------------------------------------------------------------
    // Stage 1: cell address to the char ROM, glyph line held for stage 2.
    // char_xy is driven even outside the box; the in_box flag masks it.
    // ------------------------------------------------------------------
    logic [3:0] line_s1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            char_xy <= '0;
            line_s1 <= '0;
        end else begin
            char_xy <= {ry[7:4], rx[6:3]};
            line_s1 <= ry[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: font ROM line address from the returned char code.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) font_addr <= '0;
        else        font_addr <= {char_code, line_s1};
    end

    // Side info travels stages 1..3 to meet the font ROM output.
    signal_delay #(
        .WIDTH   ($bits(side_t)),
        .CLK_DEL (3)
    ) u_side_delay (
        .clk   (pclk),
        .rst_n (rst_n),
        .din   (side_s0),
        .dout  (side_s3)
    );

    // Timing and counters are delayed the full 4 cycles to stay aligned
    // with rgb_out.
    signal_delay #(
        .WIDTH   ($bits(timing_t)),
        .CLK_DEL (4)
    ) u_timing_delay (
        .clk   (pclk),
        .rst_n (rst_n),
        .din   (timing_s0),
        .dout  (timing_s4)
    );

    // ------------------------------------------------------------------
    // Stage 4: composite. Blanking wins over everything, then set glyph
    // pixels, then (opaque mode only) the box background.
    // ------------------------------------------------------------------
    logic pix;
    assign pix = font_pixel(char_pixels, side_s3.bit_idx);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= '0;
        end else if (side_s3.blank) begin
            rgb_out <= '0;
        end else if (side_s3.in_box && pix) begin
            rgb_out <= LETTER_COLOR;
        end else if (side_s3.in_box && OPAQUE_BOX) begin
            rgb_out <= BG_COLOR;
        end else begin
            rgb_out <= side_s3.rgb;
        end
    end

    assign hcount_out = timing_s4.hcount;
    assign hsync_out  = timing_s4.hsync;
    assign hblnk_out  = timing_s4.hblnk;
    assign vcount_out = timing_s4.vcount;
    assign vsync_out  = timing_s4.vsync;
    assign vblnk_out  = timing_s4.vblnk;

endmodule

// File: tb/tb_draw_rect_char_16x16.sv
// -----------------------------------------------------------------------------
// tb_draw_rect_char_16x16
// Directed testbench for draw_rect_char_16x16 with XPOS=100, YPOS=50,
// LETTER_COLOR=12'hFFF, BG_COLOR=12'h00F. Inputs are driven on the falling
// edge and outputs sampled on the falling edge, half a cycle from the active
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_draw_rect_char_16x16;

    logic        pclk;
    logic        rst_n;
    logic [10:0] hcount_in;
    logic        hsync_in;
    logic        hblnk_in;
    logic [10:0] vcount_in;
    logic        vsync_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [6:0]  char_code;
    logic [7:0]  char_pixels;
    logic [7:0]  char_xy;
    logic [10:0] font_addr;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    int n_vec = 0;
    int n_err = 0;

    draw_rect_char_16x16 #(
        .XPOS         (11'd100),
        .YPOS         (11'd50),
        .LETTER_COLOR (12'hFFF),
        .BG_COLOR     (12'h00F)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .hcount_in   (hcount_in),
        .hsync_in    (hsync_in),
        .hblnk_in    (hblnk_in),
        .vcount_in   (vcount_in),
        .vsync_in    (vsync_in),
        .vblnk_in    (vblnk_in),
        .rgb_in      (rgb_in),
        .char_code   (char_code),
        .char_pixels (char_pixels),
        .char_xy     (char_xy),
        .font_addr   (font_addr),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .hsync_out   (hsync_out),
        .hblnk_out   (hblnk_out),
        .vsync_out   (vsync_out),
        .vblnk_out   (vblnk_out),
        .rgb_out     (rgb_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v,
                         input logic [11:0] rgb, input logic [6:0] code,
                         input logic [7:0] pix);
        hcount_in   = h;
        vcount_in   = v;
        rgb_in      = rgb;
        char_code   = code;
        char_pixels = pix;
    endtask

    // Wait long enough for the whole pipeline to reflect steady inputs.
    task automatic settle();
        repeat (5) @(negedge pclk);
    endtask

    initial begin
        // ---------------- reset with arbitrary inputs ----------------
        rst_n    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        hblnk_in = 1'b0;
        vblnk_in = 1'b0;
        drive(11'd140, 11'd82, 12'hABC, 7'h53, 8'hFF);
        repeat (3) @(negedge pclk);
        check("rst_rgb_out",   32'(rgb_out),    32'h0);
        check("rst_char_xy",   32'(char_xy),    32'h0);
        check("rst_font_addr", 32'(font_addr),  32'h0);
        check("rst_hcount",    32'(hcount_out), 32'h0);
        check("rst_vcount",    32'(vcount_out), 32'h0);
        check("rst_hsync",     32'(hsync_out),  32'h0);

        // ---------------- release: address path and latency ----------------
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        drive(11'd140, 11'd82, 12'hABC, 7'h53, 8'h80);
        rst_n = 1'b1;
        @(negedge pclk);
        check("char_xy_lat1",   32'(char_xy),   32'h25);
        @(negedge pclk);
        check("font_addr_lat2", 32'(font_addr), 32'h530);
        @(negedge pclk);
        check("rgb_not_yet_3",  32'(rgb_out),    32'h0);
        check("hcnt_not_yet_3", 32'(hcount_out), 32'h0);
        @(negedge pclk);
        check("rgb_first_4",    32'(rgb_out),    32'hFFF);
        check("hcnt_first_4",   32'(hcount_out), 32'd140);
        check("vcnt_first_4",   32'(vcount_out), 32'd82);

        // next pixel in same glyph line: bit 1 of 8'h80 is clear
        drive(11'd141, 11'd82, 12'hABC, 7'h53, 8'h80);
        settle();
        check("pix_clear_rgb", 32'(rgb_out),    32'hABC);
        check("pix_clear_h",   32'(hcount_out), 32'd141);

        // different row/line: ry=35 -> row 2, line 3
        drive(11'd140, 11'd85, 12'hABC, 7'h7F, 8'h80);
        settle();
        check("char_xy_line3",   32'(char_xy),   32'h25);
        check("font_addr_line3", 32'(font_addr), 32'h7F3);

        // ---------------- box edges ----------------
        drive(11'd227, 11'd82, 12'h0F0, 7'h41, 8'hFF);
        settle();
        check("edge_h227_in", 32'(rgb_out), 32'hFFF);
        drive(11'd228, 11'd82, 12'h0F0, 7'h41, 8'hFF);
        settle();
        check("edge_h228_out", 32'(rgb_out), 32'h0F0);
        drive(11'd99, 11'd82, 12'h0F0, 7'h41, 8'hFF);
        settle();
        check("edge_h99_out", 32'(rgb_out), 32'h0F0);
        drive(11'd140, 11'd305, 12'h0F0, 7'h41, 8'hFF);
        settle();
        check("edge_v305_in", 32'(rgb_out), 32'hFFF);
        drive(11'd140, 11'd306, 12'h0F0, 7'h41, 8'hFF);
        settle();
        check("edge_v306_out", 32'(rgb_out), 32'h0F0);
        drive(11'd140, 11'd49, 12'h0F0, 7'h41, 8'hFF);
        settle();
        check("edge_v49_out", 32'(rgb_out), 32'h0F0);

        // ---------------- blanking overrides box ----------------
        drive(11'd140, 11'd82, 12'h0F0, 7'h41, 8'hFF);
        hblnk_in = 1'b1;
        settle();
        check("hblnk_rgb",   32'(rgb_out),   32'h000);
        check("hblnk_out",   32'(hblnk_out), 32'h1);
        hblnk_in = 1'b0;
        vblnk_in = 1'b1;
        settle();
        check("vblnk_rgb",   32'(rgb_out),   32'h000);
        check("vblnk_out",   32'(vblnk_out), 32'h1);
        vblnk_in = 1'b0;
        settle();
        check("unblank_rgb", 32'(rgb_out),   32'hFFF);

        // ---------------- sync delay is exactly 4 cycles ----------------
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(negedge pclk);
        check("hsync_lat3", 32'(hsync_out), 32'h0);
        check("vsync_lat3", 32'(vsync_out), 32'h0);
        @(negedge pclk);
        check("hsync_lat4", 32'(hsync_out), 32'h1);
        check("vsync_lat4", 32'(vsync_out), 32'h1);
        hsync_in = 1'b0;
        vsync_in = 1'b0;

        // ---------------- clear glyph pixel inside / outside box ----------------
        drive(11'd140, 11'd82, 12'h0F0, 7'h20, 8'h00);
        settle();
`ifdef CHAR_BG_EN
        check("bg_in_box", 32'(rgb_out), 32'h00F);
`else
        check("bg_in_box", 32'(rgb_out), 32'h0F0);
`endif
        drive(11'd228, 11'd82, 12'h0F0, 7'h20, 8'h00);
        settle();
        check("bg_out_box", 32'(rgb_out), 32'h0F0);

        // ---------------- asynchronous reset mid-frame ----------------
        drive(11'd140, 11'd82, 12'h123, 7'h53, 8'hFF);
        settle();
        check("pre_reset_rgb", 32'(rgb_out), 32'hFFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb",  32'(rgb_out),    32'h0);
        check("async_rst_hcnt", 32'(hcount_out), 32'h0);
        check("async_rst_xy",   32'(char_xy),    32'h0);
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (3) @(negedge pclk);
        check("post_rst_rgb_3", 32'(rgb_out), 32'h0);
        @(negedge pclk);
        check("post_rst_rgb_4", 32'(rgb_out),    32'hFFF);
        check("post_rst_h_4",   32'(hcount_out), 32'd140);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
